// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: opcode encodings, FSM states,
// regfile constants and small opcode decode helpers.
package mem_stage_pkg;

    localparam int MemOpBus = 4;
    typedef logic [MemOpBus-1:0] mem_op_t;

    localparam mem_op_t MEMOP_NONE = 4'd0;
    localparam mem_op_t MEMOP_LB   = 4'd1;
    localparam mem_op_t MEMOP_LH   = 4'd2;
    localparam mem_op_t MEMOP_LW   = 4'd3;
    localparam mem_op_t MEMOP_LBU  = 4'd4;
    localparam mem_op_t MEMOP_LHU  = 4'd5;
    localparam mem_op_t MEMOP_SB   = 4'd6;
    localparam mem_op_t MEMOP_SH   = 4'd7;
    localparam mem_op_t MEMOP_SW   = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic        RstEnable   = 1'b0;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    // Access width of an opcode; unknown encodings behave like NONE.
    function automatic size_e op_size(mem_op_t op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: return SZ_BYTE;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return SZ_HALF;
            MEMOP_LW, MEMOP_SW:            return SZ_WORD;
            default:                       return SZ_NONE;
        endcase
    endfunction

    function automatic logic is_store(mem_op_t op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    function automatic logic is_signed_load(mem_op_t op);
        return (op == MEMOP_LB) || (op == MEMOP_LH);
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(mem_op_t op, logic [1:0] lane);
        case (op_size(op))
            SZ_HALF: return lane[0];
            SZ_WORD: return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane steering for the data bus: byte enables and replicated
// store data on the request side, lane extraction and extension on the load side.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_op_t          req_op_i,
    input  logic [1:0]       req_lane_i,
    input  logic [XLEN-1:0]  req_data_i,
    output logic [3:0]       be_o,
    output logic [XLEN-1:0]  wdata_o,
    input  mem_op_t          ld_op_i,
    input  logic [1:0]       ld_lane_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [XLEN-1:0]  ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request side: enables follow the access width, halfwords ignore addr[0].
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = req_data_i;
        case (op_size(req_op_i))
            SZ_BYTE: begin
                be_o    = 4'b0001 << req_lane_i;
                wdata_o = {(XLEN/8){req_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = req_lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {(XLEN/16){req_data_i[15:0]}};
            end
            SZ_WORD: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        case (ld_lane_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half   = ld_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = rdata_i;
        case (op_size(ld_op_i))
            SZ_BYTE: ld_data_o = is_signed_load(ld_op_i) ? {{(XLEN-8){ld_byte[7]}}, ld_byte}
                                                         : {{(XLEN-8){1'b0}}, ld_byte};
            SZ_HALF: ld_data_o = is_signed_load(ld_op_i) ? {{(XLEN-16){ld_half[15]}}, ld_half}
                                                         : {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through and runs a
// req/ack bus transaction for loads and stores, stalling until it completes.
// Outputs are registered and feed the regfile write port directly.
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned accesses into a one-cycle
// misalign pulse instead of a bus access.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_memop,
    input  logic              ex_wd,
    input  logic [4:0]        ex_wreg,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [ADDR_W-1:0] ex_maddr,
    input  logic [XLEN-1:0]   ex_sdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              stall_req,
    output logic              wb_we,
    output logic [4:0]        wb_waddr,
    output logic [XLEN-1:0]   wb_wdata,
    output logic              misalign
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    mem_op_t           op_q, op_d;
    logic              wd_q, wd_d, flush_q, flush_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [1:0]        lane_q, lane_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_waddr_q, wb_waddr_d;
    logic [XLEN-1:0]   wb_wdata_q, wb_wdata_d;
    logic              stall_c, is_mem, trap;
    logic [3:0]        req_be;
    logic [XLEN-1:0]   req_wdata, ld_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    mem_align #(.XLEN(XLEN)) u_align (
        .req_op_i   (ex_memop),
        .req_lane_i (ex_maddr[1:0]),
        .req_data_i (ex_sdata),
        .be_o       (req_be),
        .wdata_o    (req_wdata),
        .ld_op_i    (op_q),
        .ld_lane_i  (lane_q),
        .rdata_i    (mem_rdata),
        .ld_data_o  (ld_data)
    );

    assign is_mem = op_size(ex_memop) != SZ_NONE;

    // Next-state, bus request and writeback selection; a flush seen at any point
    // in BUSY is remembered so the eventual writeback can be dropped.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        op_d        = op_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        lane_d      = lane_q;
        flush_d     = flush_q;
        wb_we_d     = wb_we_q;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        stall_c     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap        = is_misaligned(ex_memop, ex_maddr[1:0]);
        misalign_d  = 1'b0;
`else
        trap        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (!is_mem) begin
                        wb_we_d    = ex_wd;
                        wb_waddr_d = ex_wreg;
                        wb_wdata_d = ex_wdata;
                    end else if (trap) begin
                        wb_we_d    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
`endif
                    end else begin
                        stall_c     = 1'b1;
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(ex_memop);
                        mem_addr_d  = {ex_maddr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = is_store(ex_memop) ? req_wdata : '0;
                        op_d        = ex_memop;
                        wd_d        = ex_wd;
                        wreg_d      = ex_wreg;
                        lane_d      = ex_maddr[1:0];
                        flush_d     = 1'b0;
                        wb_we_d     = 1'b0;
                    end
                end else begin
                    wb_we_d = 1'b0;
                end
            end
            BUSY: begin
                stall_c = !mem_ack;
                if (flush) flush_d = 1'b1;
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    wb_we_d   = 1'b0;
                    if (!is_store(op_q) && wd_q && !flush_q && !flush) begin
                        wb_we_d    = WriteEnable;
                        wb_waddr_d = wreg_q;
                        wb_wdata_d = ld_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            op_q        <= MEMOP_NONE;
            wd_q        <= 1'b0;
            wreg_q      <= 5'd0;
            lane_q      <= 2'd0;
            flush_q     <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= 5'd0;
            wb_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            op_q        <= op_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            lane_q      <= lane_d;
            flush_q     <= flush_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // One-cycle misalign pulse following a trapped access.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) misalign_q <= 1'b0;
        else                  misalign_q <= misalign_d;
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign stall_req = (rst != RstEnable) && stall_c;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_we     = wb_we_q;
    assign wb_waddr  = wb_waddr_q;
    assign wb_wdata  = wb_wdata_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RISC-V core, between the execute stage and the register file write port. Non-memory results pass through; loads and stores run a request/acknowledge transaction on the data bus, stalling the pipeline until it completes. Results are registered, so the outputs double as the MEM/WB latch and drive the regfile `we`/`waddr`/`wdata` inputs directly.

## Interface
Parameters
- `ADDR_W`, 32: data-bus address width.
- `XLEN`, 32: data width.

Ports
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset; **asynchronous, active-low** (`RstEnable` = 1'b0).
- `ex_valid` in 1: an instruction is presented this cycle.
- `ex_memop` in 4: memory operation code: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- `ex_wd` in 1: the instruction writes a register.
- `ex_wreg` in 5: destination register.
- `ex_wdata` in XLEN: ALU result, used for non-load writeback.
- `ex_maddr` in ADDR_W: effective address.
- `ex_sdata` in XLEN: store data.
- `flush` in 1: discard the current instruction's writeback.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = store.
- `mem_addr` out ADDR_W: word-aligned address, `[1:0]` = 0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out XLEN: store data, lane-replicated.
- `mem_rdata` in XLEN: load data, valid with `mem_ack`.
- `mem_ack` in 1: single-cycle completion pulse.
- `stall_req` out 1: hold the upstream stages.
- `wb_we` out 1: to regfile `we`.
- `wb_waddr` out 5: to regfile `waddr`.
- `wb_wdata` out XLEN: to regfile `wdata`.
- `misalign` out 1: one-cycle misaligned-access pulse (only with the macro).

## Operation
- FSM states: IDLE, BUSY.
- **IDLE with a non-memory op** (`ex_valid` and memop NONE):
  - Next edge: `wb_we`=`ex_wd`, `wb_waddr`=`ex_wreg`, `wb_wdata`=`ex_wdata`.
  - No stall.
- **IDLE with an aligned load or store:**
  - `stall_req`=1 combinationally.
  - Next edge: latch op, `wreg` and address lane; drive `mem_req`=1, `mem_addr`, `mem_be`, `mem_wdata`, `mem_we`; go to BUSY; `wb_we`←0.
- **BUSY:**
  - `mem_req` and all request fields are held stable.
  - `stall_req`=!`mem_ack`.
  - On the `mem_ack` edge: `mem_req`←0, go to IDLE, and write back (below).
  - Load writeback: `wb_we`=latched `wd`, `wb_wdata` = the selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - Store writeback: `wb_we`=0.
- **Idle cycles:** with `ex_valid`=0 in IDLE, `wb_we`←0 at the next edge.
- **Store lanes:**
  - SB: `be` = 1 << `addr[1:0]`, data byte replicated ×4.
  - SH: `be` = 0011 or 1100 by `addr[1]`, halfword replicated ×2.
  - SW: `be` = 1111.
- **Load lanes:** LB/LBU select byte `addr[1:0]`; LH/LHU select halfword `addr[1]`.
- **Flush:**
  - In IDLE: suppresses capture; `wb_we`←0.
  - In BUSY: the bus transaction still completes (no abort); the writeback is suppressed.
- **x0:** `wb_waddr`=0 is passed through unchanged; the regfile discards it.

## Timing
- Reset (async assert) values:
  - state=IDLE; `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - `wb_we`=0, `wb_waddr`=0, `wb_wdata`=0; `misalign`=0.
  - `stall_req`=0 while reset is asserted.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: `mem_req` rises 1 cycle after presentation; writeback appears the cycle after `mem_ack`.
  - Minimum 3 cycles for a memory op with ack in the first BUSY cycle.
- Upstream holds `ex_*` stable while `stall_req`=1. The new instruction is taken in the cycle after the writeback edge.
- `mem_ack` outside BUSY is ignored.
- Reset asserted mid-BUSY: drop to IDLE immediately with `mem_req`=0 and no writeback.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
- Defined:
  - Misaligned access (LH/LHU/SH with `addr[0]`; LW/SW with `addr[1:0]`≠0) issues no bus request and no stall.
  - `wb_we`←0 and `misalign` pulses 1 for one cycle at the next edge.
- Undefined:
  - The low address bits are ignored: halfword access uses `addr[1]` only; word access uses `addr[1:0]`=0.
  - The access proceeds normally.
  - `misalign` is tied to 0.

## Structure
- In the shared defines header:
  - `MemOpBus` width and the nine opcode constants (NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8).
  - FSM state encodings.
  - The existing `RstEnable`/`WriteEnable`/`ZeroWord`.
- Sub-module `mem_align`: purely combinational lane steering.
  - Store side: `be`/`wdata`.
  - Load side: extract and extend.
- FSM and registers stay in `mem_stage`.

## Test plan
- ALU op: `ex_wreg`=5, `ex_wdata`=0x1234, `ex_wd`=1 → next cycle `wb_we`=1, `waddr`=5, `wdata`=0x1234; `stall_req` never high.
- LB at 0x1003, `mem_rdata`=0x80FF_FF00, ack after 2 BUSY cycles → `mem_addr`=0x1000, `be`=1000; `stall_req` high 3 cycles; `wb_wdata`=0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH at 0x2002, `ex_sdata`=0xAAAA_BEEF → `mem_we`=1, `be`=1100, `mem_wdata`=0xBEEF_BEEF; `wb_we`=0.
- Flush asserted during BUSY of LW to x7, ack=1 → `mem_req` drops after ack; `wb_we` stays 0.
- Reset asserted in BUSY → `mem_req`=0 asynchronously; after release, an ALU op completes in 1 cycle.
- With the macro defined: LW at 0x3002 → no `mem_req`; `misalign`=1 for 1 cycle; `wb_we`=0. Without it: `mem_addr`=0x3000, normal load.
